mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares the single data-memory port between the load unit and the store buffer's drain path.
- Loads normally take priority. A committed store wins when the store buffer is under pressure or has been starved too long.
- Tracks one outstanding memory transaction at a time: returns load data tagged with its ROB address, and pulses the store buffer's pop on store completion.
- Squashes in-flight loads on pipeline flush; never squashes committed stores.

## Interface
Parameters:
- ADDR_W, 16: memory address width
- DATA_W, 16: memory data width
- TAG_W, $clog2(`ROB_LENGTH): ROB tag width
- HIGH_WATER, `STORE_BUFFER_LENGTH-1: store-buffer occupancy at or above which stores win
- STARVE_LIMIT, 8: cycles a valid store may be passed over before it wins

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- flush  in  1  pipeline flush; squashes loads only
- ld_valid  in  1  load request present
- ld_addr  in  ADDR_W  load address
- ld_tag  in  TAG_W  load ROB tag
- ld_ready  out  1  load accepted this cycle (combinational)
- ld_resp_valid  out  1  load data valid (registered)
- ld_resp_data  out  DATA_W  load data
- ld_resp_tag  out  TAG_W  ROB tag of returned load
- st_valid  in  1  store-buffer head is committed and ready
- st_addr  in  ADDR_W  head store address
- st_data  in  DATA_W  head store data
- st_count  in  $clog2(`STORE_BUFFER_LENGTH+1)  store-buffer occupancy
- st_pop  out  1  one-cycle pulse: head store written; drives the store buffer's pop
- mem_req  out  1  memory request (registered)
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid / write acknowledged
- mem_rdata  in  DATA_W  read data

## Operation
- **FSM states:** IDLE, REQ, WAIT.
- **IDLE – selection:**
  - Store selected if st_valid and (st_count >= HIGH_WATER or starve_ctr == STARVE_LIMIT or !ld_valid).
  - Otherwise load selected if ld_valid and !flush.
  - On selection, capture we/addr/wdata/tag into request registers and go to REQ.
  - ld_ready = IDLE & load selected & !flush.
- **IDLE – blocked cycle:** in the cycle st_pop is high, no store is selected, because st_valid still shows the old head. A load may still be selected.
- **REQ:**
  - mem_req = 1; hold request fields stable until mem_gnt.
  - mem_gnt → WAIT.
  - flush with a load in REQ → IDLE, no memory access, no response.
- **WAIT:**
  - On mem_rvalid → IDLE.
  - Load: next cycle ld_resp_valid = 1 with captured tag and registered mem_rdata, unless drop is set.
  - Store: next cycle st_pop = 1.
  - flush with a load in WAIT sets drop. The response is consumed silently. drop clears on return to IDLE.
- **Starvation counter starve_ctr:**
  - Increments each cycle st_valid is high and a load is selected instead.
  - Saturates at STARVE_LIMIT.
  - Cleared on store selection or when st_valid is low.
- **Flush:** never affects stores in any state.
- **Ordering:** load/store address disambiguation and forwarding are the load unit's responsibility; this block does not check addresses.
- **Reset:**
  - state = IDLE, mem_req = 0, mem_we = 0, st_pop = 0, ld_resp_valid = 0, drop = 0, starve_ctr = 0.
  - Request registers = 0.
  - Reset mid-transaction abandons it; late mem_rvalid in IDLE is ignored.

## Timing
- Cycle 0: accept in IDLE.
- Cycle 1: mem_req high. mem_gnt may arrive in the same cycle.
- mem_rvalid arrives no earlier than the cycle after gnt.
- Cycle rvalid+1: ld_resp_valid or st_pop pulse; state is IDLE.
- Minimum cycles per transaction: 3 cycles from accept to the response/st_pop pulse; the next accept can occur in the cycle after rvalid, 3 cycles after the previous accept.
- Back-to-back: a new request may be accepted in the IDLE cycle carrying the previous response pulse, except a store while st_pop is high.
- ld_resp_valid and st_pop are single-cycle pulses.

## Structure
- Shared package (nand_cpu.svh): `STORE_BUFFER_LENGTH, `ROB_LENGTH.
- Also in the package: mem_req_t struct {we, addr, wdata, tag} and the arb_state_t enum {IDLE, REQ, WAIT}.
- Sub-module: starve_counter (saturating counter with inc/clr/sat), instantiated once.

## Test plan
- **Load only:** ld_valid, addr=0x0040, tag=5; gnt same cycle; rvalid 2 cycles later with data=0xBEEF → ld_resp_valid one cycle after rvalid, data 0xBEEF, tag 5.
- **Contention, low pressure:** both valid, st_count=1 → load wins. With ld_valid held, the store wins after starve_ctr reaches 8; st_pop pulses exactly once.
- **High water:** st_count=`STORE_BUFFER_LENGTH-1 with ld_valid → store selected first; mem_we=1, mem_wdata=st_data.
- **Flush in REQ:** flush before gnt → mem_req drops next cycle, no response. Flush in WAIT → rvalid yields no ld_resp_valid.
- **Flush during store WAIT:** flush has no effect; st_pop still pulses. Store stays blocked in the st_pop cycle; the next store is accepted one cycle later.
- **Reset mid-WAIT:** n_rst low → all outputs 0 next cycle; stray rvalid ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared sizes, request record and arbiter state type for the data-memory port.
package mem_port_arbiter_pkg;
  localparam int STORE_BUFFER_LENGTH = 8;
  localparam int ROB_LENGTH = 16;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;
  localparam int ROB_TAG_W = $clog2(ROB_LENGTH);
  localparam int SB_COUNT_W = $clog2(STORE_BUFFER_LENGTH + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [ROB_TAG_W-1:0]  tag;
  } mem_req_t;
endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// starve_counter: saturating count of cycles a waiting store has been passed over.
module starve_counter #(
  parameter int LIMIT = 8,
  parameter int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);
  logic [W-1:0] cnt_q;
  assign sat_o = cnt_q == W'(LIMIT);
  always_ff @(posedge clk) begin
    if (!n_rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i && !sat_o) cnt_q <= cnt_q + W'(1);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between loads and store-buffer drain, one transaction in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int TAG_W = ROB_TAG_W,
  parameter int HIGH_WATER = STORE_BUFFER_LENGTH - 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  flush,
  input  logic                  ld_valid,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [TAG_W-1:0]      ld_tag,
  output logic                  ld_ready,
  output logic                  ld_resp_valid,
  output logic [DATA_W-1:0]     ld_resp_data,
  output logic [TAG_W-1:0]      ld_resp_tag,
  input  logic                  st_valid,
  input  logic [ADDR_W-1:0]     st_addr,
  input  logic [DATA_W-1:0]     st_data,
  input  logic [SB_COUNT_W-1:0] st_count,
  output logic                  st_pop,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);
  arb_state_t        state_q;
  mem_req_t          req_q, req_d;
  logic              mem_req_q, drop_q, st_pop_q, ld_resp_valid_q;
  logic [DATA_W-1:0] ld_resp_data_q;
  logic [TAG_W-1:0]  ld_resp_tag_q;
  logic              idle, st_sel, ld_sel, ld_flush, starve_sat;
  assign idle = state_q == IDLE;
  // st_valid still shows the old head while st_pop is high, so stores sit out that cycle
  assign st_sel = idle && st_valid && !st_pop_q &&
                  (st_count >= SB_COUNT_W'(HIGH_WATER) || starve_sat || !ld_valid);
  assign ld_sel = idle && !st_sel && ld_valid && !flush;
  assign ld_flush = flush && !req_q.we;
  assign ld_ready = ld_sel;
  always_comb begin
    req_d.we = st_sel;
    req_d.addr = st_sel ? st_addr : ld_addr;
    req_d.wdata = st_sel ? st_data : '0;
    req_d.tag = st_sel ? '0 : ld_tag;
  end
  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .n_rst (n_rst),
    .inc_i (st_valid && ld_sel),
    .clr_i (st_sel || !st_valid),
    .sat_o (starve_sat)
  );
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      req_q <= '0;
      mem_req_q <= 1'b0;
      drop_q <= 1'b0;
      st_pop_q <= 1'b0;
      ld_resp_valid_q <= 1'b0;
      ld_resp_data_q <= '0;
      ld_resp_tag_q <= '0;
    end else begin
      st_pop_q <= 1'b0;
      ld_resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (st_sel || ld_sel) begin
          req_q <= req_d;
          mem_req_q <= 1'b1;
          drop_q <= 1'b0;
          state_q <= REQ;
        end
        REQ: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          drop_q <= ld_flush;
          state_q <= WAIT;
        end else if (ld_flush) begin
          mem_req_q <= 1'b0;
          state_q <= IDLE;
        end
        WAIT: if (mem_rvalid) begin
          state_q <= IDLE;
          drop_q <= 1'b0;
          st_pop_q <= req_q.we;
          ld_resp_valid_q <= !req_q.we && !drop_q && !flush;
          if (!req_q.we) begin
            ld_resp_data_q <= mem_rdata;
            ld_resp_tag_q <= req_q.tag;
          end
        end else if (ld_flush) drop_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_req = mem_req_q;
  assign mem_we = req_q.we;
  assign mem_addr = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign st_pop = st_pop_q;
  assign ld_resp_valid = ld_resp_valid_q;
  assign ld_resp_data = ld_resp_data_q;
  assign ld_resp_tag = ld_resp_tag_q;
endmodule
